// File: rtl/result_row_collector.sv
// -----------------------------------------------------------------------------
// result_row_collector
//
// Purpose:
//   Gathers one frame of convolution results, written row by row over many
//   parallel lanes, into a RESULT_D x RESULT_H x RESULT_W register array. Once
//   the final word of the frame (last lane, last row) arrives, it streams the
//   whole frame out one word per cycle with a valid/ready handshake. Storage is
//   ordered channel-major, then row, then column, and that is the drain order.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   wr_address   per-lane row address, lane L = d*RESULT_W + w
//   wr_data      per-lane result word, same lane packing as wr_address
//   wr_en        per-lane write strobe
//   collect_rdy  high while the block accepts writes
//   out_data     word currently presented on the drain port
//   out_val      out_data valid (high for every drain cycle)
//   out_rdy      downstream accepts out_data this cycle
//   out_last     high with the final word of the frame
//   overflow     sticky: a write arrived while draining and was dropped
// -----------------------------------------------------------------------------
module result_row_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int RESULT_D   = 2,
   parameter int RESULT_W   = 3,
   parameter int RESULT_H   = 3,
   localparam int RES_WIDTH = DATA_WIDTH * 4,
   localparam int RESULT_H_ADDR_WIDTH = (RESULT_H > 1) ? $clog2(RESULT_H) : 1,
   localparam int LANES     = RESULT_D * RESULT_W,
   localparam int WORDS     = LANES * RESULT_H
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [LANES*RESULT_H_ADDR_WIDTH-1:0] wr_address,
   input  logic [LANES*RES_WIDTH-1:0]           wr_data,
   input  logic [LANES-1:0]                     wr_en,
   output logic                                 collect_rdy,
   output logic [RES_WIDTH-1:0]                 out_data,
   output logic                                 out_val,
   input  logic                                 out_rdy,
   output logic                                 out_last,
   output logic                                 overflow
);

   localparam int AW        = RESULT_H_ADDR_WIDTH;
   localparam int IDX_WIDTH = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] DRAIN   = 1'b1;

   logic [0:0]           state;
   logic [IDX_WIDTH-1:0] drain_idx;
   logic [RES_WIDTH-1:0] store [WORDS];

   logic in_collect;
   logic in_drain;
   logic frame_done;
   logic last_word;

   assign in_collect = (state == COLLECT);
   assign in_drain   = (state == DRAIN);

   // The frame is complete when the highest lane writes the highest row; every
   // other lane's final row is assumed to have arrived no later than that.
   assign frame_done = in_collect && wr_en[LANES-1] &&
                       (wr_address[(LANES-1)*AW +: AW] == AW'(RESULT_H - 1));

   assign last_word  = (drain_idx == IDX_WIDTH'(WORDS - 1));

   assign collect_rdy = in_collect;
   assign out_val     = in_drain;
   assign out_last    = in_drain && last_word;
   assign out_data    = store[drain_idx];

   // Control FSM: COLLECT until the frame-ending write, then DRAIN until the
   // last word is accepted. drain_idx only moves on an accepted transfer, so a
   // stalled downstream sees the same word held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= COLLECT;
         drain_idx <= '0;
      end else begin
         case (state)
            COLLECT: begin
               drain_idx <= '0;
               if (frame_done) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_rdy) begin
                  if (last_word) begin
                     state     <= COLLECT;
                     drain_idx <= '0;
                  end else begin
                     drain_idx <= drain_idx + 1'b1;
                  end
               end
            end
            default: begin
               state     <= COLLECT;
               drain_idx <= '0;
            end
         endcase
      end
   end

   // Any strobe while draining is a lost write; remember it until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (in_drain && (|wr_en)) begin
         overflow <= 1'b1;
      end
   end

   // One register per (d, h, w). Each word listens only to its own lane and
   // only to an exact row match, so out-of-range row addresses never hit any
   // word. The array is deliberately not reset: it is always fully rewritten
   // before it is drained.
   for (genvar gd = 0; gd < RESULT_D; gd++) begin : g_chan
      for (genvar gh = 0; gh < RESULT_H; gh++) begin : g_row
         for (genvar gw = 0; gw < RESULT_W; gw++) begin : g_col
            localparam int LANE = gd * RESULT_W + gw;
            localparam int IDX  = gd * RESULT_H * RESULT_W + gh * RESULT_W + gw;

            logic hit;

            assign hit = in_collect && wr_en[LANE] &&
                         (wr_address[LANE*AW +: AW] == AW'(gh));

            always_ff @(posedge clk) begin
               if (hit) begin
                  store[IDX] <= wr_data[LANE*RES_WIDTH +: RES_WIDTH];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_result_row_collector.sv
// -----------------------------------------------------------------------------
// tb_result_row_collector
//
// Purpose:
//   Directed bench for result_row_collector with the default geometry
//   (2 channels x 3 rows x 3 columns, 32-bit words). A small array holds what
//   each storage word should contain; completed frames are pushed from it into
//   a queue, and drained words are popped from the queue and compared.
// -----------------------------------------------------------------------------
module tb_result_row_collector;

   localparam int DW    = 8;
   localparam int RD    = 2;
   localparam int RW    = 3;
   localparam int RH    = 3;
   localparam int RES   = DW * 4;
   localparam int AW    = 2;
   localparam int LANES = RD * RW;
   localparam int WORDS = LANES * RH;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [LANES*AW-1:0]   wr_address;
   logic [LANES*RES-1:0]  wr_data;
   logic [LANES-1:0]      wr_en;
   logic                  collect_rdy;
   logic [RES-1:0]        out_data;
   logic                  out_val;
   logic                  out_rdy;
   logic                  out_last;
   logic                  overflow;

   int checks = 0;
   int passed = 0;

   logic [RES-1:0] model [WORDS];
   logic [RES-1:0] sb [$];

   result_row_collector #(
      .DATA_WIDTH(DW),
      .RESULT_D(RD),
      .RESULT_W(RW),
      .RESULT_H(RH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wr_address(wr_address),
      .wr_data(wr_data),
      .wr_en(wr_en),
      .collect_rdy(collect_rdy),
      .out_data(out_data),
      .out_val(out_val),
      .out_rdy(out_rdy),
      .out_last(out_last),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_writes();
      wr_en      = '0;
      wr_address = '0;
      wr_data    = '0;
   endtask

   task automatic set_lane(input int l, input int h, input logic [RES-1:0] val);
      wr_en[l]              = 1'b1;
      wr_address[l*AW +: AW] = AW'(h);
      wr_data[l*RES +: RES] = val;
   endtask

   // Writes row h on every lane with value d*100 + h*10 + w + base.
   task automatic write_row(input int h, input int base);
      for (int l = 0; l < LANES; l++) begin
         int d = l / RW;
         int w = l % RW;
         logic [RES-1:0] v = RES'(d * 100 + h * 10 + w + base);
         set_lane(l, h, v);
         model[d*RH*RW + h*RW + w] = v;
      end
      tick();
      clear_writes();
   endtask

   task automatic write_frame(input int base);
      for (int h = 0; h < RH; h++) write_row(h, base);
   endtask

   task automatic push_frame();
      for (int i = 0; i < WORDS; i++) sb.push_back(model[i]);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_out_val", out_val, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_collect_rdy", collect_rdy, 1'b1);
      check("rst_overflow", overflow, 1'b0);
      tick();
      reset = 1'b1;
   endtask

   // mode 0: out_rdy always high; mode 1: out_rdy pattern 1,0,0 repeating.
   // On cycle inj_cycle the given lanes write inj_data to row 0.
   task automatic drain(input int mode, input int inj_cycle, input logic [LANES-1:0] inj_en,
                        input logic [RES-1:0] inj_data, input int max_xfer);
      int xfers = 0;
      int cyc   = 0;
      while (sb.size() > 0 && xfers < max_xfer && cyc < 200) begin
         out_rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (cyc == inj_cycle) begin
            for (int l = 0; l < LANES; l++) begin
               if (inj_en[l]) set_lane(l, 0, inj_data);
            end
         end
         #1;
         check("drain_out_val", out_val, 1'b1);
         check("drain_out_data", out_data, sb[0]);
         check("drain_out_last", out_last, sb.size() == 1);
         if (out_rdy) begin
            void'(sb.pop_front());
            xfers++;
         end
         tick();
         clear_writes();
         cyc++;
      end
      out_rdy = 1'b0;
      if (cyc >= 200) begin
         checks++;
         $error("[TB] FAIL drain_timeout observed=%0d words left expected=0", sb.size());
      end
   endtask

   task automatic check_idle();
      #1;
      check("idle_collect_rdy", collect_rdy, 1'b1);
      check("idle_out_val", out_val, 1'b0);
      check("idle_out_last", out_last, 1'b0);
   endtask

   initial begin
      reset   = 1'b1;
      out_rdy = 1'b0;
      clear_writes();
      @(negedge clk);
      do_reset();

      $display("[TB] full frame");
      write_frame(0);
      push_frame();
      drain(0, -1, '0, '0, 1000);
      check_idle();

      $display("[TB] back-to-back frame with backpressure");
      write_frame(1000);
      push_frame();
      drain(1, -1, '0, '0, 1000);
      check_idle();

      $display("[TB] write during drain");
      write_frame(2000);
      push_frame();
      drain(0, 3, 6'b000001, 32'hDEAD, 1000);
      check_idle();
      check("overflow_set", overflow, 1'b1);
      write_frame(3000);
      push_frame();
      drain(0, -1, '0, '0, 1000);
      check("overflow_sticky", overflow, 1'b1);

      $display("[TB] out-of-range row address");
      do_reset();
      write_row(0, 4000);
      write_row(1, 4000);
      set_lane(2, 3, 32'hBEEF);
      tick();
      clear_writes();
      #1;
      check("oor_overflow", overflow, 1'b0);
      check("oor_collect_rdy", collect_rdy, 1'b1);
      write_row(2, 4000);
      push_frame();
      drain(0, -1, '0, '0, 1000);
      check("oor_overflow_after", overflow, 1'b0);

      $display("[TB] reset mid-drain");
      write_frame(5000);
      push_frame();
      drain(0, -1, '0, '0, 5);
      sb.delete();
      do_reset();
      write_frame(6000);
      push_frame();
      #1;
      check("new_frame_first_word", out_data, 32'd6000);
      drain(0, -1, '0, '0, 1000);

      $display("[TB] early frame trigger");
      set_lane(5, 2, 32'h7777);
      model[WORDS-1] = 32'h7777;
      tick();
      clear_writes();
      push_frame();
      drain(0, 0, '1, 32'h5555, 1000);
      check_idle();
      check("early_overflow", overflow, 1'b1);

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
